serial_adder: RTL

//  Bit-serial adder: one fullAdder cell plus a registered carry adds two WIDTH-bit operands LSB-first, one bit per clock.

---
 rtl/serial_adder_pkg.sv | 23 ++
 rtl/serial_adder_full_adder.sv | 13 +
 rtl/serial_adder.sv | 90 +++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding, default width
// and the counter-width helper.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

  // ceil(log2(width)), never less than one bit
  function automatic int cnt_width(input int width);
    int w;
    w = 1;
    for (int i = 1; i < 32; i++) begin
      if ((1 << w) < width) w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder.sv
// Single-bit full adder cell shared with the ripple-carry adder.
module fullAdder (
  input  logic a,
  input  logic b,
  input  logic in,
  output logic s,
  output logic c
);

  assign s = a ^ b ^ in;
  assign c = (a & b) | (a & in) | (b & in);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full adder cell and a carry register add two
// WIDTH-bit operands LSB-first, one bit per clock.
import serial_adder_pkg::*;

module serial_adder #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_reg;
  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic [WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0] sum_reg;
  logic             carry_reg;
  logic             cout_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             fa_s;
  logic             fa_c;

  fullAdder u_fa (
    .a  (sa_reg[0]),
    .b  (sb_reg[0]),
    .in (carry_reg),
    .s  (fa_s),
    .c  (fa_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
      sa_reg    <= '0;
      sb_reg    <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          // DONE accepts a new request like IDLE so ops can run back-to-back
          if (start) begin
            sa_reg    <= a;
            sb_reg    <= b;
            carry_reg <= cin;
            cnt_reg   <= '0;
            state_reg <= S_RUN;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_RUN: begin
          sa_reg    <= sa_reg >> 1;
          sb_reg    <= sb_reg >> 1;
          acc_reg   <= {fa_s, acc_reg[WIDTH-1:1]};
          carry_reg <= fa_c;
          if (cnt_reg == LAST_BIT) begin
            // acc holds the lower WIDTH-1 result bits; the MSB is this cycle's sum
            sum_reg   <= {fa_s, acc_reg[WIDTH-1:1]};
            cout_reg  <= fa_c;
            state_reg <= S_DONE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;
  assign busy = (state_reg == S_RUN);
  assign done = (state_reg == S_DONE);

endmodule
